// File: rtl/gmsk_symbol_feeder.sv
// GMSK modulator front end: sample/symbol timebase, burst framing with guard
// symbols, 1-deep payload holding register and GSM differential encoding.
//
//   state | meaning
//   IDLE  | no burst; a latched burst_start waits for the next symbol boundary
//   LEAD  | leading guard symbols (fill bit 1); payload may preload holding reg
//   DATA  | payload symbols, one holding-register bit per boundary
//   TRAIL | trailing guard symbols (fill bit 1)
module gmsk_symbol_feeder #(
   parameter int CLOCKS_PER_SAMPLE  = 8,
   parameter int SAMPLES_PER_SYMBOL = 128,
   parameter int BURST_BITS         = 148,
   parameter int GUARD_SYMBOLS      = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clk_en,
   input  logic       burst_start,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   output logic       sample_strobe,
   output logic       symbol_strobe,
   output logic [2:0] symbol_window,
   output logic       burst_active,
   output logic       underrun
);

   localparam int DIV_W = $clog2(CLOCKS_PER_SAMPLE);
   localparam int SYM_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
   localparam int CNT_MAX = (BURST_BITS > GUARD_SYMBOLS) ? BURST_BITS : GUARD_SYMBOLS;
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCKS_PER_SAMPLE - 1);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SAMPLES_PER_SYMBOL - 1);

   typedef enum logic [1:0] {IDLE, LEAD, DATA, TRAIL} state_t;

   logic [DIV_W-1:0] div;
   logic [SYM_W-1:0] sym_cnt;
   logic             sample_q, symbol_q;

   state_t           state, state_n;
   logic [CNT_W-1:0] sym_left, sym_left_n;
   logic             pending, pending_n;
   logic             prev_bit, prev_n;
   logic             have, have_n;
   logic             hold, hold_n;
   logic             und_q, und_n;
   logic [2:0]       win, win_n;

   logic             step, hs, shift, b, consumed, clear_win;

   // Strobe registers freeze with clk_en; gating keeps a frozen pulse invisible
   // until the timebase runs again, so the FSM never misses a boundary.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div      <= '0;
         sym_cnt  <= '0;
         sample_q <= 1'b0;
         symbol_q <= 1'b0;
      end else if (clk_en) begin
         div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
         sample_q <= (div == DIV_LAST);
         symbol_q <= (div == DIV_LAST) && (sym_cnt == SYM_LAST);
         if (div == DIV_LAST)
            sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + SYM_W'(1);
      end
   end

   assign sample_strobe = sample_q & clk_en;
   assign symbol_strobe = symbol_q & clk_en;
   assign step          = symbol_strobe;

   assign bit_ready = clk_en & ~have & ((state == LEAD) | (state == DATA));
   assign hs        = bit_valid & bit_ready;

   always_comb begin
      state_n    = state;
      sym_left_n = sym_left;
      pending_n  = pending;
      prev_n     = prev_bit;
      have_n     = have;
      hold_n     = hold;
      und_n      = und_q;
      win_n      = win;
      shift      = 1'b0;
      b          = 1'b1;
      consumed   = 1'b0;
      clear_win  = 1'b0;

      case (state)
         IDLE: begin
            if (step && pending) begin
               pending_n  = 1'b0;
               prev_n     = 1'b1;
               und_n      = 1'b0;
               sym_left_n = CNT_W'(GUARD_SYMBOLS);
               state_n    = LEAD;
            end else if (burst_start) begin
               pending_n = 1'b1;
            end
         end
         LEAD: begin
            if (step) begin
               shift = 1'b1;
               if (sym_left == CNT_W'(1)) begin
                  sym_left_n = CNT_W'(BURST_BITS);
                  state_n    = DATA;
               end else begin
                  sym_left_n = sym_left - CNT_W'(1);
               end
            end
         end
         DATA: begin
            if (step) begin
               shift = 1'b1;
               if (have) begin
                  b      = hold;
                  have_n = 1'b0;
               end else if (hs) begin
                  b        = bit_in;
                  consumed = 1'b1;
               end else begin
                  und_n = 1'b1;
               end
               if (sym_left == CNT_W'(1)) begin
                  sym_left_n = CNT_W'(GUARD_SYMBOLS);
                  state_n    = TRAIL;
               end else begin
                  sym_left_n = sym_left - CNT_W'(1);
               end
            end
         end
         TRAIL: begin
            if (step) begin
               shift = 1'b1;
               if (sym_left == CNT_W'(1)) begin
                  clear_win = 1'b1;
                  state_n   = IDLE;
               end else begin
                  sym_left_n = sym_left - CNT_W'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (hs && !consumed) begin
         have_n = 1'b1;
         hold_n = bit_in;
      end

      if (shift) begin
         prev_n = b;
         win_n  = {win[1:0], b ^ prev_bit};
      end
      if (clear_win)
         win_n = 3'b000;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sym_left <= '0;
         pending  <= 1'b0;
         prev_bit <= 1'b1;
         have     <= 1'b0;
         hold     <= 1'b0;
         und_q    <= 1'b0;
         win      <= 3'b000;
      end else if (clk_en) begin
         state    <= state_n;
         sym_left <= sym_left_n;
         pending  <= pending_n;
         prev_bit <= prev_n;
         have     <= have_n;
         hold     <= hold_n;
         und_q    <= und_n;
         win      <= win_n;
      end
   end

   assign symbol_window = win;
   assign burst_active  = (state != IDLE);
   assign underrun      = und_q;

endmodule

// File: tb/tb_gmsk_symbol_feeder.sv
// Bench for gmsk_symbol_feeder: burst-level reference model (symbol index
// arithmetic and a queue of encoded symbols) compared every clock.
module tb_gmsk_symbol_feeder;

   localparam int CPS = 2;
   localparam int SPS = 4;
   localparam int BB  = 148;
   localparam int GS  = 8;
   localparam int SYM_CLK = CPS * SPS;

   logic       clock, reset, clk_en, burst_start, bit_in, bit_valid;
   logic       bit_ready, sample_strobe, symbol_strobe, burst_active, underrun;
   logic [2:0] symbol_window;

   gmsk_symbol_feeder #(
      .CLOCKS_PER_SAMPLE(CPS), .SAMPLES_PER_SYMBOL(SPS),
      .BURST_BITS(BB), .GUARD_SYMBOLS(GS)
   ) dut (
      .clock(clock), .reset(reset), .clk_en(clk_en), .burst_start(burst_start),
      .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
      .sample_strobe(sample_strobe), .symbol_strobe(symbol_strobe),
      .symbol_window(symbol_window), .burst_active(burst_active), .underrun(underrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int  m_e;          // enabled clocks since reset
   bit  m_idle, m_pend, m_prev, m_have, m_hold, m_und;
   int  m_n;          // symbols shifted so far in the current burst
   bit  dq[$];        // encoded symbols of the current burst, oldest first
   int  obs[4];       // DUT newest-window bit after the first four payload symbols

   always @(posedge clock) begin
      bit sym_now, rdy, hs, start, idle_pre, b, shifted;
      logic [2:0] exp_win;
      shifted = 0;
      if (reset) begin
         m_e = 0; m_idle = 1; m_pend = 0; m_n = 0; m_prev = 1;
         m_have = 0; m_hold = 0; m_und = 0; dq.delete();
      end else if (clk_en) begin
         sym_now  = (m_e > 0) && (m_e % SYM_CLK == 0);
         idle_pre = m_idle;
         rdy      = !m_have && !m_idle && (m_n < GS + BB);
         hs       = rdy && bit_valid;
         start    = 0;
         if (sym_now && !m_idle) begin
            b = 1;
            if (m_n >= GS && m_n < GS + BB) begin
               if (m_have) begin b = m_hold; m_have = 0; end
               else if (hs) begin b = bit_in; hs = 0; end
               else m_und = 1;
            end
            dq.push_back(b ^ m_prev);
            m_prev = b;
            m_n++;
            shifted = 1;
            if (m_n == 2 * GS + BB) begin m_idle = 1; dq.delete(); end
         end else if (sym_now && m_pend) begin
            m_pend = 0; m_idle = 0; m_n = 0; m_prev = 1; m_und = 0;
            dq.delete(); start = 1;
         end
         if (hs) begin m_have = 1; m_hold = bit_in; end
         if (idle_pre && !start && burst_start) m_pend = 1;
         m_e++;
      end
      #1;
      exp_win = 3'b000;
      for (int k = 0; k < 3; k++)
         if (dq.size() > k) exp_win[k] = dq[dq.size() - 1 - k];
      chk("sample_strobe", sample_strobe, clk_en && m_e > 0 && (m_e % CPS == 0));
      chk("symbol_strobe", symbol_strobe, clk_en && m_e > 0 && (m_e % SYM_CLK == 0));
      chk("bit_ready", bit_ready, clk_en && !m_have && !m_idle && (m_n < GS + BB));
      chk("burst_active", burst_active, !m_idle);
      chk("underrun", underrun, m_und);
      chk("symbol_window", symbol_window, exp_win);
      if (shifted && m_n > GS && m_n <= GS + 4) obs[m_n - GS - 1] = symbol_window[0];
   end

   // ---------------- observation counters ----------------
   int hs_cnt = 0, act_cnt = 0, hs_base = 0;
   bit pay[256];

   always @(negedge clock) begin
      if (!reset) begin
         if (burst_active) act_cnt++;
         if (bit_ready && bit_valid) hs_cnt++;
      end
   end

   always @(posedge clock) begin
      #2;
      bit_in = pay[(hs_cnt - hs_base) & 255];
   end

   // ---------------- stimulus ----------------
   task automatic cyc(int n, int vmode, int en_mode);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #2;
         case (vmode)
            0:       bit_valid = 1'b0;
            1:       bit_valid = 1'b1;
            default: bit_valid = ($urandom_range(0, 7) != 0);
         endcase
         if (en_mode == 1) clk_en = ($urandom_range(0, 15) != 0);
         burst_start = 1'b0;
      end
   endtask

   task automatic pulse_start();
      @(posedge clock); #2;
      burst_start = 1'b1;
   endtask

   task automatic wait_active(bit lvl, int lim, int vmode, string nm);
      int k = 0;
      while (burst_active !== lvl && k < lim) begin cyc(1, vmode, 0); k++; end
      chk(nm, burst_active, lvl);
   endtask

   initial begin
      int cnt, a0;
      reset = 1; clk_en = 1; burst_start = 0; bit_valid = 0;
      for (int i = 0; i < 256; i++) pay[i] = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 0;

      cnt = 0;
      while (!symbol_strobe && cnt < 50) begin @(posedge clock); #2; cnt++; end
      chk("first_symbol_clock", cnt, SYM_CLK);
      cyc(20, 1, 0);

      // burst A: all-ones payload, data always offered
      hs_base = hs_cnt; a0 = act_cnt;
      pulse_start();
      wait_active(1, 40, 1, "A_active_rise");
      wait_active(0, 3000, 1, "A_active_fall");
      chk("A_handshakes", hs_cnt - hs_base, BB);
      chk("A_active_clocks", act_cnt - a0, (2 * GS + BB) * SYM_CLK);
      chk("A_underrun", underrun, 0);

      // burst B: 1,0,0,1 lead-in, gap, ignored start, clk_en freeze
      for (int i = 0; i < 256; i++) pay[i] = 1'($urandom_range(0, 1));
      pay[0] = 1; pay[1] = 0; pay[2] = 0; pay[3] = 1;
      cyc(5, 1, 0);
      hs_base = hs_cnt; a0 = act_cnt;
      pulse_start();
      cyc(200, 1, 0);
      pulse_start();
      cyc(30, 2, 0);
      cyc(20, 0, 0);
      cyc(40, 2, 0);
      cnt = 0;
      while (!symbol_strobe && cnt < 20) begin cyc(1, 2, 0); cnt++; end
      cnt = 0;
      do begin
         cyc(1, 2, 0);
         cnt++;
         if (cnt == 3) clk_en = 1'b0;
         if (cnt == 103) clk_en = 1'b1;
      end while (!symbol_strobe && cnt < 300);
      chk("freeze_symbol_spacing", cnt, SYM_CLK + 100);
      wait_active(0, 3000, 2, "B_active_fall");
      chk("B_active_clocks", act_cnt - a0, (2 * GS + BB) * SYM_CLK + 100);
      chk("B_underrun_sticky", underrun, 1);
      chk("B_win0_sym0", obs[0], 0);
      chk("B_win0_sym1", obs[1], 1);
      chk("B_win0_sym2", obs[2], 0);
      chk("B_win0_sym3", obs[3], 1);
      cyc(30, 2, 0);
      chk("B_underrun_idle", underrun, 1);

      // burst C: random clk_en, then reset mid-DATA
      pulse_start();
      wait_active(1, 40, 2, "C_active_rise");
      chk("C_underrun_cleared", underrun, 0);
      cyc(250, 2, 1);
      @(posedge clock); #2;
      clk_en = 1; reset = 1;
      #1;
      chk("reset_outputs_zero",
          {bit_ready, sample_strobe, symbol_strobe, symbol_window, burst_active, underrun}, 0);
      repeat (2) @(posedge clock);
      #2 reset = 0;
      cyc(100, 2, 0);
      chk("post_reset_idle", burst_active, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
